reg_read_stage: RTL and testbench
=================================

// Module: reg_read_stage
// PURPOSE
//   Decode/operand-read stage directly downstream of instruction fetch (top: rd/rs1/rs2/imm).
//   Holds the 32-entry integer register file. Reads rs1/rs2, sign-extends imm and registers
//   the result into a valid/ready pipeline slot for execute.
//   Accepts one writeback per cycle from the later stage.
// PARAMETERS
//   XLEN   32  data width of each register and of the operand outputs
//   NREGS  32  number of architectural registers; the address width is fixed at 5
//   IMM_W  12  width of the incoming immediate field
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-low
//   in_valid   in   1      fetch presents a decoded instruction
//   in_ready   out  1      stage can accept this cycle
//   rs1        in   5      source register 1 address
//   rs2        in   5      source register 2 address
//   rd         in   5      destination register address
//   imm        in   IMM_W  raw immediate
//   wb_en      in   1      writeback strobe
//   wb_addr    in   5      writeback register address
//   wb_data    in   XLEN   writeback value
//   out_valid  out  1      operand slot holds a valid instruction
//   out_ready  in   1      execute consumes the slot this cycle
//   rs1_data   out  XLEN   operand 1
//   rs2_data   out  XLEN   operand 2
//   imm_sext   out  XLEN   imm sign-extended from bit IMM_W-1
//   rd_q       out  5      registered rd, forwarded to execute
// BEHAVIOUR
//   - Reset (rst==0, asynchronous):
//     - All NREGS registers clear to 0.
//     - out_valid=0; rs1_data, rs2_data, imm_sext and rd_q clear to 0.
//     - in_ready=1 on the first cycle after deassertion.
//   - Register file:
//     - Write on posedge clk when wb_en && wb_addr!=0.
//     - x0 always reads 0; writes to x0 are ignored.
//   - Read: combinational from rs1/rs2.
//   - Handshake:
//     - in_ready = !out_valid || out_ready.
//     - Accept = in_valid && in_ready.
//   - Slot update:
//     - On accept, the slot loads read data, imm_sext and rd, and out_valid<=1. Latency 1 cycle.
//     - If out_ready && !accept, then out_valid<=0.
//     - Otherwise the slot holds all values stable, including while stalled.
//   - Simultaneous events:
//     - Accept and consume in the same cycle: the new instruction replaces the old one. No bubble.
//     - Writeback to a register captured in a stalled slot does NOT update the slot.
//     - Execute must handle that hazard itself.
//   - Sign extension: imm_sext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm}.
//   - Reset mid-operation:
//     - Any in-flight slot is dropped (out_valid=0) and register contents are lost.
//     - The writeback in that cycle is discarded.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     - On accept, if wb_en && wb_addr==rsN && rsN!=0, rsN_data loads wb_data (write-through).
//   REGFILE_BYPASS_EN undefined:
//     - rsN_data loads the pre-write register value.
//     - The written value is visible to instructions accepted in later cycles only.
// TESTING
//   1. Reset: rst low 10ns.
//      -> out_valid=0, all outputs 0, in_ready=1.
//      -> Reading x1..x31 returns 0.
//   2. Write then read:
//      - wb x5=0xDEADBEEF.
//      - Next cycle accept rs1=5, rs2=0.
//      -> One cycle later: out_valid=1, rs1_data=0xDEADBEEF, rs2_data=0.
//   3. Same-cycle write/read of x7 (old 0x11, wb 0x22), rs1=7:
//      -> rs1_data=0x22 with REGFILE_BYPASS_EN.
//      -> rs1_data=0x11 without it.
//   4. x0 write: wb x0=0xFFFFFFFF, then read rs1=0.
//      -> rs1_data=0.
//   5. Stall: out_ready=0 with the slot full.
//      -> in_ready=0; outputs are held for 5 cycles.
//      -> Release: the new accept replaces the slot with no bubble.
//   6. Sign extension:
//      - imm=0x800 -> imm_sext=0xFFFFF800.
//      - imm=0x7FF -> imm_sext=0x000007FF.
//      -> rd_q tracks rd=31.

Source files
------------

// File: rtl/reg_read_stage.sv
//------------------------------------------------------------------------------
// Module      : reg_read_stage
// Description : Operand-read stage with a 32-entry register file and a one-deep
//               valid/ready slot. Define REGFILE_BYPASS_EN for wb write-through.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_read_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int IMM_W = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [IMM_W-1:0] imm,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm_sext,
  output logic [4:0]      rd_q
);

  localparam int ADDR_W = 5;

  logic [XLEN-1:0]   rf_q [NREGS];
  logic [XLEN-1:0]   rs1_rd;
  logic [XLEN-1:0]   rs2_rd;
  logic [XLEN-1:0]   imm_ext;
  logic              accept;

  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0]   imm_sext_q,  imm_sext_d;
  logic [ADDR_W-1:0] rd_slot_q,   rd_slot_d;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wb_en && (wb_addr == ADDR_W'(i))) rf_q[i] <= wb_data;
      end
    end
  end

  always_comb begin
    rs1_rd = '0;
    rs2_rd = '0;
    if (rs1 != '0) rs1_rd = rf_q[rs1];
    if (rs2 != '0) rs2_rd = rf_q[rs2];
`ifdef REGFILE_BYPASS_EN
    if (wb_en && (wb_addr == rs1) && (rs1 != '0)) rs1_rd = wb_data;
    if (wb_en && (wb_addr == rs2) && (rs2 != '0)) rs2_rd = wb_data;
`else
`endif
  end

  assign imm_ext  = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_sext_d  = imm_sext_q;
    rd_slot_d   = rd_slot_q;
    if (accept) begin
      out_valid_d = 1'b1;
      rs1_data_d  = rs1_rd;
      rs2_data_d  = rs2_rd;
      imm_sext_d  = imm_ext;
      rd_slot_d   = rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_sext_q  <= '0;
      rd_slot_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_sext_q  <= imm_sext_d;
      rd_slot_q   <= rd_slot_d;
    end
  end

  assign out_valid = out_valid_q;
  assign rs1_data  = rs1_data_q;
  assign rs2_data  = rs2_data_q;
  assign imm_sext  = imm_sext_q;
  assign rd_q      = rd_slot_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_read_stage.sv
//------------------------------------------------------------------------------
// Module      : tb_reg_read_stage
// Description : Scoreboard bench for reg_read_stage with a register-file model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_read_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [11:0] imm = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] rs1_data, rs2_data, imm_sext;
  logic [4:0]  rd_q;

  reg_read_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_sext(imm_sext), .rd_q(rd_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] im;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mregs [32];
  bit          m_full = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : mregs[a];
`ifdef REGFILE_BYPASS_EN
    if (wb_en && wb_addr == a && a != 5'd0) v = wb_data;
`endif
    return v;
  endfunction

  // Reference model: acceptance rule, register file and immediate by plain arithmetic.
  always @(posedge clk) begin
    if (rst) begin
      bit   acc;
      exp_t e;
      int   s;
      acc = in_valid && (!m_full || out_ready);
      if (acc) begin
        s    = int'($signed(imm));
        e.r1 = mread(rs1);
        e.r2 = mread(rs2);
        e.im = 32'(s);
        e.rd = rd;
        sbq.push_back(e);
      end
      m_full = acc ? 1'b1 : (out_ready ? 1'b0 : m_full);
      if (wb_en && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
    end
  end

  // Monitor: compares the presented slot against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_rs1_data", rs1_data, 32'd0);
      chk("rst_rs2_data", rs2_data, 32'd0);
      chk("rst_imm_sext", imm_sext, 32'd0);
      chk("rst_rd_q", {27'd0, rd_q}, 32'd0);
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_full || out_ready)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          chk("rs1_data", rs1_data, sbq[0].r1);
          chk("rs2_data", rs2_data, sbq[0].r2);
          chk("imm_sext", imm_sext, sbq[0].im);
          chk("rd_q", {27'd0, rd_q}, {27'd0, sbq[0].rd});
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic drv(input logic iv, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [4:0] d, input logic [11:0] im, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd, input logic ordy);
    @(posedge clk); #1;
    in_valid = iv; rs1 = a1; rs2 = a2; rd = d; imm = im;
    wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    sbq.delete();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
  endtask

  initial begin
    model_reset();
    #12 rst = 1'b1;

    for (int i = 1; i < 32; i++) drv(1, 5'(i), 5'(i), 5'(i), 12'(i), 0, 0, 0, 1);

    drv(0, 0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 1);
    drv(1, 5'd5, 5'd0, 5'd1, 12'h001, 0, 0, 0, 1);

    drv(0, 0, 0, 0, 0, 1, 5'd7, 32'h11, 1);
    drv(1, 5'd7, 5'd7, 5'd2, 12'h002, 1, 5'd7, 32'h22, 1);
    drv(1, 5'd7, 5'd0, 5'd3, 12'h003, 0, 0, 0, 1);

    drv(0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 1);
    drv(1, 5'd0, 5'd0, 5'd4, 12'h004, 0, 0, 0, 1);

    drv(1, 5'd5, 5'd7, 5'd9, 12'h123, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drv(1, 5'd7, 5'd5, 5'd10, 12'h456, 1, 5'd5, 32'(i), 0);
    drv(1, 5'd5, 5'd7, 5'd11, 12'h789, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);

    drv(1, 0, 0, 5'd31, 12'h800, 0, 0, 0, 1);
    drv(1, 0, 0, 5'd31, 12'h7FF, 0, 0, 0, 1);
    drv(1, 5'd3, 0, 5'd30, 12'hFFF, 1, 5'd3, 32'hCAFE0003, 0);

    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h66666666;
    @(posedge clk); #1;
    rst = 1'b1;
    drv(1, 5'd3, 5'd6, 5'd1, 12'h0, 0, 0, 0, 1);
    drv(1, 5'd5, 5'd7, 5'd2, 12'h0, 0, 0, 0, 1);

    for (int n = 0; n < 3000; n++) begin
      drv(($urandom_range(0, 3) != 0),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom),
          12'($urandom), ($urandom_range(0, 1) == 1),
          5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 9) < 7));
    end

    for (int n = 0; n < 3; n++) drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("drain", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
